// File: rtl/bru_pkg.sv
// rtl/bru_pkg.sv - shared opcode encodings and decode helper for the branch resolve unit
//
// Contents:
//   OP_JAL .. OP_BGEU : 4-bit branch/jump opcode encodings
//   is_valid_op()     : true for any opcode the unit resolves (top bit set)
package bru_pkg;

  localparam logic [3:0] OP_JAL  = 4'b1000;
  localparam logic [3:0] OP_JALR = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;
  localparam logic [3:0] OP_BLT  = 4'b1100;
  localparam logic [3:0] OP_BGE  = 4'b1101;
  localparam logic [3:0] OP_BLTU = 4'b1110;
  localparam logic [3:0] OP_BGEU = 4'b1111;

  // All eight defined opcodes occupy 4'b1xxx.
  function automatic logic is_valid_op(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/branch_cond_cmp.sv
// rtl/branch_cond_cmp.sv - combinational branch condition evaluator
//
// Ports:
//   op   in  4     branch opcode
//   a    in  XLEN  rs1 operand
//   b    in  XLEN  rs2 operand
//   cond out 1     comparison result for conditional branches (0 for jumps and unknown ops)
module branch_cond_cmp
  import bru_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            cond
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (a == b);
  assign lt_s = ($signed(a) < $signed(b));
  assign lt_u = (a < b);

  always_comb begin
    cond = 1'b0;
    case (op)
      OP_BEQ:  cond = eq;
      OP_BNE:  cond = !eq;
      OP_BLT:  cond = lt_s;
      OP_BGE:  cond = !lt_s;
      OP_BLTU: cond = lt_u;
      OP_BGEU: cond = !lt_u;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered branch/jump resolution stage with valid/ready handshake
//
// Optional feature macro: BRU_PERF_CNT_EN (resolved-branch and mispredict counters).
//
// Ports:
//   CLK, RSTn            clock, synchronous active-low reset
//   in_valid/in_ready    request handshake; in_ready = !out_valid || out_ready
//   in_op, in_a, in_b    opcode and operands
//   in_pc, in_imm        branch PC and sign-extended offset
//   in_pred_*            fetch-stage prediction (direction, target)
//   flush                drops the held result and any same-cycle request
//   out_valid/out_ready  result handshake
//   out_taken            resolved direction
//   out_target           resolved next PC
//   out_link             in_pc + 4
//   out_mispredict       prediction disagreed with resolution
//   perf_branches        resolved valid-op count (0 without BRU_PERF_CNT_EN)
//   perf_mispredicts     mispredict count (0 without BRU_PERF_CNT_EN)
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OP_W  = 4,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_target,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_link,
  output logic             out_mispredict,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispredicts
);

  // ---------------- resolution (combinational on in_*) ----------------
  logic [3:0]      op4;
  logic            op_valid;
  logic            is_jal;
  logic            is_jalr;
  logic            cond;
  logic            res_taken;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] pc_plus_4;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] res_target;
  logic            res_mispredict;

  assign op4 = in_op[3:0];
  // Opcodes wider than 4 bits must have zero upper bits to be recognised.
  assign op_valid = ((in_op >> 4) == '0) && is_valid_op(op4);
  assign is_jal   = op_valid && (op4 == OP_JAL);
  assign is_jalr  = op_valid && (op4 == OP_JALR);

  branch_cond_cmp #(.XLEN(XLEN)) u_cmp (
    .op   (op4),
    .a    (in_a),
    .b    (in_b),
    .cond (cond)
  );

  assign pc_plus_imm = in_pc + in_imm;
  assign pc_plus_4   = in_pc + XLEN'(4);
  assign jalr_target = (in_a + in_imm) & {{(XLEN-1){1'b1}}, 1'b0};

  always_comb begin
    res_taken      = 1'b0;
    res_target     = pc_plus_4;
    res_mispredict = 1'b0;
    if (op_valid) begin
      res_taken = is_jal || is_jalr || cond;
      if (is_jalr)
        res_target = jalr_target;
      else if (res_taken)
        res_target = pc_plus_imm;
      // Unknown opcodes never report a mispredict.
      res_mispredict = (res_taken != in_pred_taken) ||
                       (res_taken && (in_pred_target != res_target));
    end
  end

  // ---------------- handshake and output register ----------------
  logic            valid_q, valid_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] link_q, link_d;
  logic            mis_q, mis_d;
  logic            opv_q, opv_d;
  logic            accept;
  logic            out_hs;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign out_hs   = valid_q && out_ready && !flush;

  always_comb begin
    valid_d  = valid_q;
    taken_d  = taken_q;
    target_d = target_q;
    link_d   = link_q;
    mis_d    = mis_q;
    opv_d    = opv_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      taken_d  = res_taken;
      target_d = res_target;
      link_d   = pc_plus_4;
      mis_d    = res_mispredict;
      opv_d    = op_valid;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      valid_q  <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= '0;
      link_q   <= '0;
      mis_q    <= 1'b0;
      opv_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      link_q   <= link_d;
      mis_q    <= mis_d;
      opv_q    <= opv_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_taken      = taken_q;
  assign out_target     = target_q;
  assign out_link       = link_q;
  assign out_mispredict = mis_q;

  // ---------------- performance counters ----------------
`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (out_hs && opv_q) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
      if (mis_q)
        mp_cnt_d = mp_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign perf_branches    = br_cnt_q;
  assign perf_mispredicts = mp_cnt_q;
`else
  logic unused_hs;
  assign unused_hs        = out_hs ^ opv_q;
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule
